// File: rtl/instr_sequencer_pkg.sv
// rtl/instr_sequencer_pkg.sv - shared state, opcode and register-bank strobe encodings
// Purpose : constants shared by instr_sequencer and the register bank.
// Contents: state_t sequencer states, LDREGF strobe encodings, opcode values,
//           needs_writeback() opcode classifier.
package instr_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_READ   = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALTED = 3'd5
    } state_t;

    localparam logic [1:0] LDREGF_IDLE  = 2'b00;
    localparam logic [1:0] LDREGF_READ  = 2'b01;
    localparam logic [1:0] LDREGF_WRITE = 2'b10;

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_RSVD = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    // Opcodes whose result lands in DR and therefore need the WB strobe.
    function automatic logic needs_writeback(input logic [3:0] op);
        logic wb;
        wb = 1'b0;
        case (op)
            OP_ADD, OP_AND, OP_NOT, OP_LD, OP_LDR, OP_LEA: wb = 1'b1;
            default:                                       wb = 1'b0;
        endcase
        return wb;
    endfunction

endpackage

// File: rtl/ir_field_decode.sv
// rtl/ir_field_decode.sv - combinational instruction-word field extraction
// Purpose : split the latched instruction word into its operand fields.
// Ports   : ir        in  16  latched instruction
//           opcode    out 4   ir[15:12]
//           register1 out 3   SR1 select, ir[8:6]
//           register2 out 3   SR2 select, ir[2:0]
//           dr        out 3   destination register, ir[11:9]
//           immsel    out 1   ir[5]
//           imm5      out 16  ir[4:0] sign-extended
module ir_field_decode (
    input  logic [15:0] ir,
    output logic [3:0]  opcode,
    output logic [2:0]  register1,
    output logic [2:0]  register2,
    output logic [2:0]  dr,
    output logic        immsel,
    output logic [15:0] imm5
);

    assign opcode    = ir[15:12];
    assign dr        = ir[11:9];
    assign register1 = ir[8:6];
    assign immsel    = ir[5];
    assign register2 = ir[2:0];
    assign imm5      = {{11{ir[4]}}, ir[4:0]};

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode/read/execute/writeback instruction sequencer
// Purpose : fetches instruction words, latches them in IR and sequences the
//           register bank strobes around an external execute stage.
// Ports   : CLK, RESET (async active-high)
//           MEM_DATA/MEM_RDY in   instruction word and its valid
//           EXEC_DONE        in   execute stage complete
//           MEM_REQ, PC      out  fetch request and address
//           IR + fields      out  OPCODE, REGISTER1, REGISTER2, DR, IMMSEL, IMM5
//           LDREGF           out  register bank strobe
//           HALT             out  sequencer halted on TRAP
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h3000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] MEM_DATA,
    input  logic        MEM_RDY,
    input  logic        EXEC_DONE,
    output logic        MEM_REQ,
    output logic [15:0] PC,
    output logic [15:0] IR,
    output logic [3:0]  OPCODE,
    output logic [2:0]  REGISTER1,
    output logic [2:0]  REGISTER2,
    output logic [2:0]  DR,
    output logic [1:0]  LDREGF,
    output logic        IMMSEL,
    output logic [15:0] IMM5,
    output logic        HALT
);

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        mem_req_q, mem_req_d;
    logic [1:0]  ldregf_q, ldregf_d;
    logic        halt_q, halt_d;

    ir_field_decode u_ir_field_decode (
        .ir        (ir_q),
        .opcode    (OPCODE),
        .register1 (REGISTER1),
        .register2 (REGISTER2),
        .dr        (DR),
        .immsel    (IMMSEL),
        .imm5      (IMM5)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;

        case (state_q)
            ST_FETCH: begin
                // The first cycle after reset has MEM_REQ still low; a word is
                // only accepted once the request is actually on the bus.
                if (mem_req_q && MEM_RDY) begin
                    ir_d    = MEM_DATA;
                    pc_d    = pc_q + 16'd1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (OPCODE == OP_TRAP) begin
                    state_d = ST_HALTED;
                end else if (OPCODE == OP_RSVD) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_READ: state_d = ST_EXEC;
            ST_EXEC: begin
                if (EXEC_DONE) begin
                    state_d = needs_writeback(OPCODE) ? ST_WB : ST_FETCH;
                end
            end
            ST_WB:     state_d = ST_FETCH;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_FETCH;
        endcase

        // Outputs are registered from the next state so they line up with
        // the state they describe without a combinational path to the pins.
        mem_req_d = (state_d == ST_FETCH);
        halt_d    = (state_d == ST_HALTED);
        case (state_d)
            ST_READ: ldregf_d = LDREGF_READ;
            ST_WB:   ldregf_d = LDREGF_WRITE;
            default: ldregf_d = LDREGF_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 16'h0000;
            mem_req_q <= 1'b0;
            ldregf_q  <= LDREGF_IDLE;
            halt_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mem_req_q <= mem_req_d;
            ldregf_q  <= ldregf_d;
            halt_q    <= halt_d;
        end
    end

    assign MEM_REQ = mem_req_q;
    assign PC      = pc_q;
    assign IR      = ir_q;
    assign LDREGF  = ldregf_q;
    assign HALT    = halt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - scoreboard bench for instr_sequencer
module tb_instr_sequencer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] MEM_DATA = 16'h0000;
    logic        MEM_RDY = 1'b0;
    logic        EXEC_DONE = 1'b0;
    logic        MEM_REQ;
    logic [15:0] PC;
    logic [15:0] IR;
    logic [3:0]  OPCODE;
    logic [2:0]  REGISTER1;
    logic [2:0]  REGISTER2;
    logic [2:0]  DR;
    logic [1:0]  LDREGF;
    logic        IMMSEL;
    logic [15:0] IMM5;
    logic        HALT;

    logic        reset2 = 1'b1;
    logic [15:0] mem_data2 = 16'h0000;
    logic        mem_rdy2 = 1'b0;
    logic        exec_done2 = 1'b1;
    logic        mem_req2;
    logic [15:0] pc2;
    logic [15:0] ir2;
    logic [3:0]  opcode2;
    logic [2:0]  register1_2;
    logic [2:0]  register2_2;
    logic [2:0]  dr2;
    logic [1:0]  ldregf2;
    logic        immsel2;
    logic [15:0] imm5_2;
    logic        halt2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  ldregf;
        logic [2:0]  r1;
        logic [2:0]  r2;
        logic [2:0]  dr;
        logic        immsel;
        logic [15:0] imm5;
        logic [3:0]  op;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    always #5 CLK = ~CLK;

    instr_sequencer dut (
        .CLK(CLK), .RESET(RESET), .MEM_DATA(MEM_DATA), .MEM_RDY(MEM_RDY),
        .EXEC_DONE(EXEC_DONE), .MEM_REQ(MEM_REQ), .PC(PC), .IR(IR),
        .OPCODE(OPCODE), .REGISTER1(REGISTER1), .REGISTER2(REGISTER2), .DR(DR),
        .LDREGF(LDREGF), .IMMSEL(IMMSEL), .IMM5(IMM5), .HALT(HALT)
    );

    instr_sequencer #(.RESET_PC(16'hFFFF)) dut2 (
        .CLK(CLK), .RESET(reset2), .MEM_DATA(mem_data2), .MEM_RDY(mem_rdy2),
        .EXEC_DONE(exec_done2), .MEM_REQ(mem_req2), .PC(pc2), .IR(ir2),
        .OPCODE(opcode2), .REGISTER1(register1_2), .REGISTER2(register2_2), .DR(dr2),
        .LDREGF(ldregf2), .IMMSEL(immsel2), .IMM5(imm5_2), .HALT(halt2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] ld, input logic [2:0] r1, input logic [2:0] r2,
                            input logic [2:0] dr, input logic immsel, input logic [15:0] imm5,
                            input logic [3:0] op);
        exp_t e;
        e.ldregf = ld; e.r1 = r1; e.r2 = r2; e.dr = dr;
        e.immsel = immsel; e.imm5 = imm5; e.op = op;
        sb_q.push_back(e);
    endtask

    // Monitor: every register-bank strobe must match the next queued expectation.
    always @(negedge CLK) begin
        if (!RESET && LDREGF != 2'b00) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got LDREGF=%b expected none, IR=%h", LDREGF, IR);
            end else begin
                mon_e = sb_q.pop_front();
                chk("strobe_ldregf", {30'd0, LDREGF}, {30'd0, mon_e.ldregf});
                chk("strobe_register1", {29'd0, REGISTER1}, {29'd0, mon_e.r1});
                chk("strobe_register2", {29'd0, REGISTER2}, {29'd0, mon_e.r2});
                chk("strobe_dr", {29'd0, DR}, {29'd0, mon_e.dr});
                chk("strobe_immsel", {31'd0, IMMSEL}, {31'd0, mon_e.immsel});
                chk("strobe_imm5", {16'd0, IMM5}, {16'd0, mon_e.imm5});
                chk("strobe_opcode", {28'd0, OPCODE}, {28'd0, mon_e.op});
            end
        end
    end

    task automatic wait_fetch(input string name);
        int n;
        n = 0;
        @(negedge CLK);
        while (!MEM_REQ && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk({name, "_fetch_req"}, {31'd0, MEM_REQ}, 32'd1);
    endtask

    // Presents one word, then counts cycles from acceptance until the next
    // fetch request (or HALT). EXEC_DONE arrives exec_wait cycles late.
    task automatic run_instr(input string name, input logic [15:0] word, input int exec_wait,
                             input int exp_lat, input logic [15:0] exp_pc);
        int lat;
        wait_fetch(name);
        MEM_DATA  = word;
        MEM_RDY   = 1'b1;
        EXEC_DONE = (exec_wait == 0);
        @(posedge CLK);
        #1 MEM_RDY = 1'b0;
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
            if (lat == 3 + exec_wait) EXEC_DONE = 1'b1;
        end while (!MEM_REQ && !HALT && lat < 40);
        EXEC_DONE = 1'b0;
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_pc"}, {16'd0, PC}, {16'd0, exp_pc});
        chk({name, "_ir"}, {16'd0, IR}, {16'd0, word});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge CLK);
        chk("rst_pc", {16'd0, PC}, 32'h3000);
        chk("rst_ir", {16'd0, IR}, 32'h0000);
        chk("rst_mem_req", {31'd0, MEM_REQ}, 32'd0);
        chk("rst_ldregf", {30'd0, LDREGF}, 32'd0);
        chk("rst_halt", {31'd0, HALT}, 32'd0);

        @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        chk("req_before_edge", {31'd0, MEM_REQ}, 32'd0);
        @(negedge CLK);
        chk("req_after_edge", {31'd0, MEM_REQ}, 32'd1);

        // ADD R3,R1,R2
        push_exp(2'b01, 3'd1, 3'd2, 3'd3, 1'b0, 16'h0002, 4'h1);
        push_exp(2'b10, 3'd1, 3'd2, 3'd3, 1'b0, 16'h0002, 4'h1);
        run_instr("add", 16'h1642, 0, 5, 16'h3001);
        // AND R2,R2,#-1
        push_exp(2'b01, 3'd2, 3'd7, 3'd2, 1'b1, 16'hFFFF, 4'h5);
        push_exp(2'b10, 3'd2, 3'd7, 3'd2, 1'b1, 16'hFFFF, 4'h5);
        run_instr("and", 16'h54BF, 0, 5, 16'h3002);
        // BR: read strobe only
        push_exp(2'b01, 3'd0, 3'd2, 3'd7, 1'b0, 16'h0002, 4'h0);
        run_instr("br", 16'h0E02, 0, 4, 16'h3003);
        // reserved opcode: straight back to fetch
        run_instr("rsvd", 16'hD000, 0, 2, 16'h3004);
        // NOT with EXEC_DONE three cycles late
        push_exp(2'b01, 3'd1, 3'd7, 3'd3, 1'b1, 16'hFFFF, 4'h9);
        push_exp(2'b10, 3'd1, 3'd7, 3'd3, 1'b1, 16'hFFFF, 4'h9);
        run_instr("not_slow", 16'h967F, 3, 8, 16'h3005);

        // LDR, reset while waiting in EXEC
        wait_fetch("ldr");
        push_exp(2'b01, 3'd2, 3'd3, 3'd1, 1'b0, 16'h0003, 4'h6);
        MEM_DATA  = 16'h6283;
        MEM_RDY   = 1'b1;
        EXEC_DONE = 1'b0;
        @(posedge CLK);
        #1 MEM_RDY = 1'b0;
        repeat (3) @(negedge CLK);
        #2 RESET = 1'b1;
        #1;
        chk("async_pc", {16'd0, PC}, 32'h3000);
        chk("async_ir", {16'd0, IR}, 32'h0000);
        chk("async_opcode", {28'd0, OPCODE}, 32'd0);
        chk("async_mem_req", {31'd0, MEM_REQ}, 32'd0);
        chk("async_ldregf", {30'd0, LDREGF}, 32'd0);
        chk("async_halt", {31'd0, HALT}, 32'd0);
        @(posedge CLK);
        #1 RESET = 1'b0;

        // TRAP halts permanently, ignoring memory and execute handshakes
        run_instr("trap", 16'hF025, 0, 2, 16'h3001);
        MEM_RDY   = 1'b1;
        EXEC_DONE = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            chk("halt_hold", {31'd0, HALT}, 32'd1);
            chk("halt_no_req", {31'd0, MEM_REQ}, 32'd0);
            chk("halt_ldregf", {30'd0, LDREGF}, 32'd0);
        end
        chk("halt_pc_frozen", {16'd0, PC}, 32'h3001);
        MEM_RDY   = 1'b0;
        EXEC_DONE = 1'b0;
        #2 RESET = 1'b1;
        #1;
        chk("unhalt_pc", {16'd0, PC}, 32'h3000);
        chk("unhalt_halt", {31'd0, HALT}, 32'd0);
        chk("sb_empty", sb_q.size(), 32'd0);

        // RESET_PC = FFFF: stalled fetch, then wrap on acceptance
        @(posedge CLK);
        #1 reset2 = 1'b0;
        repeat (2) @(negedge CLK);
        chk("w_req", {31'd0, mem_req2}, 32'd1);
        chk("w_pc_reset", {16'd0, pc2}, 32'hFFFF);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("w_stall_req", {31'd0, mem_req2}, 32'd1);
            chk("w_stall_ir", {16'd0, ir2}, 32'h0000);
        end
        mem_data2 = 16'h1642;
        mem_rdy2  = 1'b1;
        @(posedge CLK);
        #1 mem_rdy2 = 1'b0;
        @(negedge CLK);
        chk("w_pc_wrap", {16'd0, pc2}, 32'h0000);
        chk("w_ir", {16'd0, ir2}, 32'h1642);
        chk("w_opcode", {28'd0, opcode2}, 32'h1);
        chk("w_register1", {29'd0, register1_2}, 32'd1);
        chk("w_register2", {29'd0, register2_2}, 32'd2);
        chk("w_dr", {29'd0, dr2}, 32'd3);
        chk("w_immsel", {31'd0, immsel2}, 32'd0);
        chk("w_imm5", {16'd0, imm5_2}, 32'h0002);
        chk("w_decode_req", {31'd0, mem_req2}, 32'd0);
        chk("w_decode_ldregf", {30'd0, ldregf2}, 32'd0);
        chk("w_decode_halt", {31'd0, halt2}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
